ahfp_float_2_fixed_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 single-precision to signed fixed-point converter with valid/ready flow control, selectable rounding, saturation and exception flags. It succeeds the combinational float-to-fixed converter in the AHFP datapath. It sits between float-producing stages and the fixed-point arithmetic units, and sustains one conversion per clock under back-pressure. The default format is Q3.29 in 32 bits, so 1.0 converts to 0x20000000.

---
 rtl/ahfp_float_2_fixed_pipe_if.sv | 26 ++
 rtl/ahfp_float_2_fixed_pipe.sv | 178 +++++++++++++++++
 tb/tb_ahfp_float_2_fixed_pipe.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ahfp_float_2_fixed_pipe_if.sv
// Operand/result stream bundle for the float-to-fixed converter.
// The converter is the slave; the producer/consumer side is the master.
interface ahfp_float_2_fixed_pipe_if #(
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_ovf;
  logic                 out_nan;
  logic [CNT_WIDTH-1:0] evt_count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ovf, out_nan, evt_count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ovf, out_nan, evt_count
  );
endinterface

// File: rtl/ahfp_float_2_fixed_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with global-stall
// valid/ready flow control, optional round-half-away, saturation and event counter.
module ahfp_float_2_fixed_pipe #(
  parameter int OUT_WIDTH = 32,
  parameter int FRAC_BITS = 29,
  parameter int ROUND     = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  ahfp_float_2_fixed_pipe_if.slave bus
);
  // Magnitude carries one bit beyond the output so MAXP+1 (the negative limit) fits.
  localparam int MW = OUT_WIDTH + 1;
  localparam int WW = OUT_WIDTH + 24;
  localparam logic [MW:0] MAXP_MAG = {3'b000, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [MW:0] MIN_MAG  = {2'b00, 1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] MAXP_OUT = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_OUT  = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

  logic                 en;
  logic                 s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  logic [7:0]           s1_exp_q, s1_exp_d;
  logic [22:0]          s1_man_q, s1_man_d;
  cls_e                 s1_cls_q, s1_cls_d;
  logic                 s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  cls_e                 s2_cls_q, s2_cls_d;
  logic [MW-1:0]        s2_mag_q, s2_mag_d;
  logic                 s2_big_q, s2_big_d, s2_rnd_q, s2_rnd_d;
  logic                 out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, out_nan_q, out_nan_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] evt_count_q, evt_count_d;

  logic [23:0]          m_full;
  int                   k, nk;
  logic [WW-1:0]        wide;
  logic                 big, rnd;
  logic [MW:0]          sum;
  logic [OUT_WIDTH-1:0] res_data;
  logic                 res_ovf, res_nan;

  assign en = !out_valid_q || bus.out_ready;

  // Shift stage: align the significand; big marks magnitudes that cannot fit MW bits.
  always_comb begin
    m_full = {1'b1, s1_man_q};
    k      = int'(s1_exp_q) - 127 + FRAC_BITS - 23;
    nk     = -k;
    wide   = '0;
    big    = 1'b0;
    rnd    = 1'b0;
    if (k > OUT_WIDTH) begin
      big = 1'b1;
    end else if (k >= 0) begin
      wide = WW'(m_full) << k;
    end else begin
      wide = WW'(m_full >> nk);
      rnd  = (m_full & (24'd1 << (nk - 1))) != '0;
    end
    big = big | (|wide[WW-1:MW]);
  end

  always_comb begin
    sum      = {1'b0, s2_mag_q} + {{MW{1'b0}}, (ROUND != 0) & s2_rnd_q};
    res_data = '0;
    res_ovf  = 1'b0;
    res_nan  = 1'b0;
    case (s2_cls_q)
      CLS_NAN: res_nan = 1'b1;
      CLS_INF: begin
        res_ovf  = 1'b1;
        res_data = s2_sign_q ? MIN_OUT : MAXP_OUT;
      end
      CLS_NORM: begin
        if (!s2_sign_q) begin
          if (s2_big_q || sum > MAXP_MAG) begin
            res_ovf  = 1'b1;
            res_data = MAXP_OUT;
          end else begin
            res_data = sum[OUT_WIDTH-1:0];
          end
        end else if (s2_big_q || sum > MIN_MAG) begin
          res_ovf  = 1'b1;
          res_data = MIN_OUT;
        end else begin
          res_data = -sum[OUT_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // NOTE: every *_d starts as its *_q so no path leaves a variable unassigned (no latch).
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_man_d    = s1_man_q;
    s1_cls_d    = s1_cls_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_d    = s2_cls_q;
    s2_mag_d    = s2_mag_q;
    s2_big_d    = s2_big_q;
    s2_rnd_d    = s2_rnd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_nan_d   = out_nan_q;
    evt_count_d = evt_count_q;
    if (en) begin
      s1_valid_d = bus.in_valid;
      s1_sign_d  = bus.in_data[31];
      s1_exp_d   = bus.in_data[30:23];
      s1_man_d   = bus.in_data[22:0];
      if (bus.in_data[30:23] == 8'h00)      s1_cls_d = CLS_ZERO;
      else if (bus.in_data[30:23] != 8'hFF) s1_cls_d = CLS_NORM;
      else if (bus.in_data[22:0] != '0)     s1_cls_d = CLS_NAN;
      else                                  s1_cls_d = CLS_INF;
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_cls_d    = s1_cls_q;
      s2_mag_d    = wide[MW-1:0];
      s2_big_d    = big;
      s2_rnd_d    = rnd;
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_data_d = res_data;
        out_ovf_d  = res_ovf;
        out_nan_d  = res_nan;
      end
    end
    if (out_valid_q && bus.out_ready && (out_ovf_q || out_nan_q) && !(&evt_count_q))
      evt_count_d = evt_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
      evt_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_nan_q   <= out_nan_d;
      evt_count_q <= evt_count_d;
    end
  end

  // NOTE: stage payload needs no reset; it is only ever consumed behind a valid bit.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_exp_q  <= s1_exp_d;
    s1_man_q  <= s1_man_d;
    s1_cls_q  <= s1_cls_d;
    s2_sign_q <= s2_sign_d;
    s2_cls_q  <= s2_cls_d;
    s2_mag_q  <= s2_mag_d;
    s2_big_q  <= s2_big_d;
    s2_rnd_q  <= s2_rnd_d;
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_nan   = out_nan_q;
  assign bus.evt_count = evt_count_q;
endmodule

// File: tb/tb_ahfp_float_2_fixed_pipe.sv
// Directed bench: a truncating and a rounding Q3.29 instance share stimulus;
// vector table plus stream, back-pressure and mid-flight reset sequences.
module tb_ahfp_float_2_fixed_pipe;
  localparam int OW  = 32;
  localparam int CW  = 16;
  localparam int NV  = 23;
  localparam int BP0 = 4;

  typedef struct packed {
    logic [31:0] din;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        ovf;
    logic        nan;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahfp_float_2_fixed_pipe_if #(.OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus0 ();
  ahfp_float_2_fixed_pipe_if #(.OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus1 ();

  ahfp_float_2_fixed_pipe #(.OUT_WIDTH(OW), .FRAC_BITS(29), .ROUND(0), .CNT_WIDTH(CW))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ahfp_float_2_fixed_pipe #(.OUT_WIDTH(OW), .FRAC_BITS(29), .ROUND(1), .CNT_WIDTH(CW))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int   checks = 0;
  int   errors = 0;
  int   exp_evt = 0;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] d, input logic [31:0] e0,
                              input logic [31:0] e1, input logic o, input logic n);
    vec_t v;
    v.din = d; v.exp0 = e0; v.exp1 = e1; v.ovf = o; v.nan = n;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d);
    bus0.in_valid = v; bus0.in_data = d;
    bus1.in_valid = v; bus1.in_data = d;
  endtask

  task automatic set_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // Called at a negedge with an empty pipeline; returns at a negedge, pipeline empty.
  task automatic run_vec(input int i);
    int lat;
    drive(1'b1, vecs[i].din);
    @(negedge clk);
    drive(1'b0, 32'h7FC0_0000);
    lat = 1;
    while (!bus0.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d latency", i), lat, 3);
    check($sformatf("v%0d data r0", i), bus0.out_data, vecs[i].exp0);
    check($sformatf("v%0d data r1", i), bus1.out_data, vecs[i].exp1);
    check($sformatf("v%0d ovf", i), {bus1.out_ovf, bus0.out_ovf}, {2{vecs[i].ovf}});
    check($sformatf("v%0d nan", i), {bus1.out_nan, bus0.out_nan}, {2{vecs[i].nan}});
    if (vecs[i].ovf || vecs[i].nan) exp_evt++;
    @(negedge clk);
    check($sformatf("v%0d evt r0", i), bus0.evt_count, exp_evt);
    check($sformatf("v%0d evt r1", i), bus1.evt_count, exp_evt);
  endtask

  initial begin
    int  sent, rcv, stall_left, stalls;
    logic seen, accepted;

    vecs[0]  = mk(32'h4080_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0); // 4.0
    vecs[1]  = mk(32'hC080_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0); // -4.0
    vecs[2]  = mk(32'h7F80_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0); // +inf
    vecs[3]  = mk(32'hFF80_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0); // -inf
    vecs[4]  = mk(32'h3F80_0000, 32'h2000_0000, 32'h2000_0000, 1'b0, 1'b0); // 1.0
    vecs[5]  = mk(32'hBF80_0000, 32'hE000_0000, 32'hE000_0000, 1'b0, 1'b0); // -1.0
    vecs[6]  = mk(32'h3F00_0000, 32'h1000_0000, 32'h1000_0000, 1'b0, 1'b0); // 0.5
    vecs[7]  = mk(32'h4040_0000, 32'h6000_0000, 32'h6000_0000, 1'b0, 1'b0); // 3.0
    vecs[8]  = mk(32'hBF40_0000, 32'hE800_0000, 32'hE800_0000, 1'b0, 1'b0); // -0.75
    vecs[9]  = mk(32'h407F_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80, 1'b0, 1'b0); // just under 4
    vecs[10] = mk(32'hC07F_FFFF, 32'h8000_0080, 32'h8000_0080, 1'b0, 1'b0);
    vecs[11] = mk(32'h7FC0_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1); // qNaN
    vecs[12] = mk(32'hFFC0_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1); // -NaN
    vecs[13] = mk(32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); // denormal
    vecs[14] = mk(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); // -0.0
    vecs[15] = mk(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); // +0.0
    vecs[16] = mk(32'h3080_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0); // 0.5 LSB
    vecs[17] = mk(32'hB080_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0); // -0.5 LSB
    vecs[18] = mk(32'h3140_0000, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0); // 1.5 LSB
    vecs[19] = mk(32'hB140_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0); // -1.5 LSB
    vecs[20] = mk(32'h3000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); // 0.25 LSB
    vecs[21] = mk(32'h7F7F_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0); // max float
    vecs[22] = mk(32'hFF7F_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);

    rst = 1'b1;
    drive(1'b0, 32'h0);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst out_valid", {bus1.out_valid, bus0.out_valid}, 2'b00);
    check("rst out_data", bus0.out_data, 32'h0);
    check("rst flags", {bus1.out_ovf, bus1.out_nan, bus0.out_ovf, bus0.out_nan}, 4'h0);
    check("rst evt", bus0.evt_count, 16'h0);
    check("rst in_ready", {bus1.in_ready, bus0.in_ready}, 2'b11);

    // Back-to-back stream: results on the 3rd, 4th and 5th cycle after the first accept.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("stream valid c%0d", c), bus0.out_valid, (c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) begin
        check($sformatf("stream data c%0d", c), bus0.out_data, vecs[BP0 + c - 3].exp0);
        check($sformatf("stream flags c%0d", c), {bus0.out_ovf, bus0.out_nan}, 2'b00);
      end
      if (c < 3) drive(1'b1, vecs[BP0 + c].din);
      else       drive(1'b0, 32'h0);
    end

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-pressure: six operands, consumer stalls four cycles at the first result.
    sent = 0; rcv = 0; stall_left = 0; stalls = 0; seen = 1'b0; accepted = 1'b0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, vecs[BP0].din);
      else if (accepted) begin
        sent++;
        if (sent < 6) drive(1'b1, vecs[BP0 + sent].din);
        else          drive(1'b0, 32'h0);
      end
      if (bus0.out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 4;
      end
      if (stall_left > 0) begin
        set_ready(1'b0);
        stall_left--;
      end else begin
        set_ready(1'b1);
      end
      #1;
      if (bus0.out_valid && !bus0.out_ready) begin
        stalls++;
        check("bp in_ready low", {bus1.in_ready, bus0.in_ready}, 2'b00);
        check("bp data held", bus0.out_data, vecs[BP0].exp0);
      end
      if (bus0.out_valid && bus0.out_ready) begin
        check($sformatf("bp data r0 #%0d", rcv), bus0.out_data, vecs[BP0 + rcv].exp0);
        check($sformatf("bp data r1 #%0d", rcv), bus1.out_data, vecs[BP0 + rcv].exp1);
        rcv++;
      end
      accepted = bus0.in_valid && bus0.in_ready;
    end
    check("bp received", rcv, 6);
    check("bp sent", sent, 6);
    check("bp stall cycles", stalls, 4);
    set_ready(1'b1);
    drive(1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp no duplicate", bus0.out_valid, 1'b0);
    end

    // Reset with three flagged operands in flight; none may be delivered afterwards.
    drive(1'b1, vecs[0].din);
    @(negedge clk);
    drive(1'b1, vecs[2].din);
    @(negedge clk);
    drive(1'b1, vecs[11].din);
    @(negedge clk);
    drive(1'b0, 32'h0);
    set_ready(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);
    exp_evt = 0;
    check("mid rst out_valid", {bus1.out_valid, bus0.out_valid}, 2'b00);
    check("mid rst evt", {bus1.evt_count, bus0.evt_count}, 32'h0);
    check("mid rst in_ready", bus0.in_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid rst flushed", {bus1.out_valid, bus0.out_valid}, 2'b00);
    end
    run_vec(BP0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
